// File: rtl/scr_pkg.sv
// rtl/scr_pkg.sv - shared encodings and record layout for the signal change recorder
package scr_pkg;

    localparam int KIND_W = 2;

    localparam logic [KIND_W-1:0] KIND_CHANGE   = 2'd0;
    localparam logic [KIND_W-1:0] KIND_SNAPSHOT = 2'd1;
    localparam logic [KIND_W-1:0] KIND_WRAP     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Record layout for the default configuration; the top packs the same
    // field order {ts, val, mask, kind} at its own parameterised widths.
    localparam int REC_WIDTH = 4;
    localparam int REC_TS_W  = 16;

    typedef struct packed {
        logic [REC_TS_W-1:0]  ts;
        logic [REC_WIDTH-1:0] val;
        logic [REC_WIDTH-1:0] mask;
        logic [KIND_W-1:0]    kind;
    } rec_t;

    function automatic int rec_bits(input int width, input int ts_w);
        return ts_w + 2 * width + KIND_W;
    endfunction

endpackage

// File: rtl/scr_fifo.sv
// rtl/scr_fifo.sv - first-word-fall-through record FIFO with occupancy count
module scr_fifo
    import scr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign level_o = count_q;

    // A pop in the same cycle frees a slot, so a push on full is still taken.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head entry is presented directly; zero when nothing is stored.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Occupancy follows the push/pop combination of this cycle.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Storage array needs no reset: empty entries are masked on read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/signal_change_recorder.sv
// rtl/signal_change_recorder.sv - timestamped change/snapshot/wrap trace of a signal bundle
module signal_change_recorder
    import scr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         sig_in,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [TS_W-1:0]          rec_ts,
    output logic [WIDTH-1:0]         rec_val,
    output logic [WIDTH-1:0]         rec_mask,
    output logic [1:0]               rec_kind,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int REC_W = rec_bits(WIDTH, TS_W);

    state_e            state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [WIDTH-1:0]  diff;
    logic              push;
    logic [TS_W-1:0]   push_ts;
    logic [WIDTH-1:0]  push_mask;
    logic [KIND_W-1:0] push_kind;
    logic [REC_W-1:0]  push_data, rd_data;
    logic              fifo_empty, fifo_full, pop, drop;
    logic              overflow_q;
    logic [7:0]        drop_cnt_q;

    assign diff = sig_in ^ prev_q;

    // Sequencing: IDLE waits for en, SNAP records the baseline, RUN records changes and wraps.
    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        prev_d    = prev_q;
        push      = 1'b0;
        push_ts   = '0;
        push_mask = '0;
        push_kind = KIND_CHANGE;
        case (state_q)
            ST_IDLE: begin
                ts_d = '0;
                if (en) state_d = ST_SNAP;
            end
            ST_SNAP: begin
                push      = 1'b1;
                push_mask = '1;
                push_kind = KIND_SNAPSHOT;
                prev_d    = sig_in;
                // The snapshot is still taken if en drops during this cycle.
                if (en) begin
                    ts_d    = TS_W'(1);
                    state_d = ST_RUN;
                end else begin
                    ts_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    ts_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    prev_d = sig_in;
                    ts_d   = ts_q + TS_W'(1);
                    // A wrap marker always goes out and absorbs any coincident change.
                    if (ts_q == '0) begin
                        push      = 1'b1;
                        push_mask = diff;
                        push_kind = KIND_WRAP;
                    end else if (diff != '0) begin
                        push      = 1'b1;
                        push_ts   = ts_q;
                        push_mask = diff;
                        push_kind = KIND_CHANGE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, timestamp and previous-sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            prev_q  <= prev_d;
        end
    end

    assign push_data = {push_ts, sig_in, push_mask, push_kind};
    assign pop       = rec_valid && rec_ready;
    assign drop      = push && fifo_full && !pop;

    scr_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .rd_data_o   (rd_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (level)
    );

    assign rec_valid = !fifo_empty;
    assign {rec_ts, rec_val, rec_mask, rec_kind} = rd_data;

    // Sticky overflow flag and saturating dropped-record counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_signal_change_recorder.sv
// tb/tb_signal_change_recorder.sv - self-checking bench for signal_change_recorder
module tb_signal_change_recorder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en0, rdy0, en1, rdy1;
    logic [3:0] sig0, sig1;
    logic       valid0, valid1, ovf0, ovf1;
    logic [15:0] ts0;
    logic [3:0]  ts1;
    logic [3:0]  val0, val1, mask0, mask1, lvl0, lvl1;
    logic [1:0]  kind0, kind1;
    logic [7:0]  drop0, drop1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signal_change_recorder #(.WIDTH(4), .TS_W(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en0), .sig_in(sig0),
        .rec_valid(valid0), .rec_ready(rdy0), .rec_ts(ts0), .rec_val(val0),
        .rec_mask(mask0), .rec_kind(kind0), .overflow(ovf0), .drop_cnt(drop0),
        .level(lvl0)
    );

    signal_change_recorder #(.WIDTH(4), .TS_W(4), .DEPTH(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en1), .sig_in(sig1),
        .rec_valid(valid1), .rec_ready(rdy1), .rec_ts(ts1), .rec_val(val1),
        .rec_mask(mask1), .rec_kind(kind1), .overflow(ovf1), .drop_cnt(drop1),
        .level(lvl1)
    );

    // Reference model: phase 0 = off, 1 = baseline due, 2 = recording.
    typedef struct {
        int         ts;
        logic [3:0] val;
        logic [3:0] mask;
        int         kind;
    } mrec_t;

    mrec_t      q0[$];
    mrec_t      q1[$];
    int         m_ph[2];
    int         m_ts[2];
    int         m_mod[2];
    logic [3:0] m_prev[2];
    int         m_ovf[2];
    int         m_drop[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_reset(input int k);
        if (k == 0) q0.delete(); else q1.delete();
        m_ph[k] = 0; m_ts[k] = 0; m_prev[k] = 4'h0; m_ovf[k] = 0; m_drop[k] = 0;
    endtask

    task automatic model_step(input int k, input logic en, input logic [3:0] sig, input logic rdy);
        bit         gen = 0;
        mrec_t      r;
        logic [3:0] d;
        r = '{0, 4'h0, 4'h0, 0};
        case (m_ph[k])
            0: if (en) m_ph[k] = 1;
            1: begin
                gen = 1;
                r = '{0, sig, 4'hF, 1};
                m_prev[k] = sig;
                m_ts[k] = en ? 1 : 0;
                m_ph[k] = en ? 2 : 0;
            end
            default: begin
                if (!en) begin
                    m_ph[k] = 0;
                    m_ts[k] = 0;
                end else begin
                    d = sig ^ m_prev[k];
                    m_prev[k] = sig;
                    if (m_ts[k] == 0) begin
                        gen = 1; r = '{0, sig, d, 2};
                    end else if (d != 4'h0) begin
                        gen = 1; r = '{m_ts[k], sig, d, 0};
                    end
                    m_ts[k] = (m_ts[k] + 1) % m_mod[k];
                end
            end
        endcase
        if (qsize(k) > 0 && rdy) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (gen) begin
            if (qsize(k) < 8) begin
                if (k == 0) q0.push_back(r); else q1.push_back(r);
            end else begin
                m_ovf[k] = 1;
                if (m_drop[k] < 255) m_drop[k]++;
            end
        end
    endtask

    task automatic model_compare(input int k);
        mrec_t f;
        bit    has;
        f = '{0, 4'h0, 4'h0, 0};
        has = qsize(k) > 0;
        if (has) f = (k == 0) ? q0[0] : q1[0];
        if (k == 0) begin
            chk("i0_valid", valid0, has);
            chk("i0_ts", ts0, f.ts);
            chk("i0_val", val0, f.val);
            chk("i0_mask", mask0, f.mask);
            chk("i0_kind", kind0, f.kind);
            chk("i0_level", lvl0, qsize(0));
            chk("i0_overflow", ovf0, m_ovf[0]);
            chk("i0_drop_cnt", drop0, m_drop[0]);
        end else begin
            chk("i1_valid", valid1, has);
            chk("i1_ts", ts1, f.ts);
            chk("i1_val", val1, f.val);
            chk("i1_mask", mask1, f.mask);
            chk("i1_kind", kind1, f.kind);
            chk("i1_level", lvl1, qsize(1));
            chk("i1_overflow", ovf1, m_ovf[1]);
            chk("i1_drop_cnt", drop1, m_drop[1]);
        end
    endtask

    // One clock: advance the model with the inputs in force, then sample after the edge.
    task automatic tick();
        model_step(0, en0, sig0, rdy0);
        model_step(1, en1, sig1, rdy1);
        @(posedge clk);
        #1;
        model_compare(0);
        model_compare(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid0, 0);
        chk("rst_level", lvl0, 0);
        chk("rst_fields", {ts0, val0, mask0, kind0, ovf0, drop0}, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [3:0] sig;
        logic       rdy;
        logic       ev;
        int         ets;
        logic [3:0] eval;
        logic [3:0] emask;
        int         ekind;
        int         elvl;
    } vec_t;

    vec_t vec[13];

    initial begin
        rst_n = 1'b0;
        en0 = 0; rdy0 = 0; sig0 = 4'h0;
        en1 = 0; rdy1 = 0; sig1 = 4'h0;
        m_mod[0] = 65536;
        m_mod[1] = 16;

        vec = '{
            '{1'b1, 4'h0, 1'b1, 1'b0, 0, 4'h0, 4'h0, 0, 0},
            '{1'b1, 4'h0, 1'b1, 1'b1, 0, 4'h0, 4'hF, 1, 1},
            '{1'b1, 4'h0, 1'b1, 1'b0, 0, 4'h0, 4'h0, 0, 0},
            '{1'b1, 4'h1, 1'b1, 1'b1, 2, 4'h1, 4'h1, 0, 1},
            '{1'b1, 4'h3, 1'b1, 1'b1, 3, 4'h3, 4'h2, 0, 1},
            '{1'b1, 4'h3, 1'b0, 1'b1, 3, 4'h3, 4'h2, 0, 1},
            '{1'b1, 4'h9, 1'b0, 1'b1, 3, 4'h3, 4'h2, 0, 2},
            '{1'b1, 4'h9, 1'b1, 1'b1, 5, 4'h9, 4'hA, 0, 1},
            '{1'b0, 4'h6, 1'b0, 1'b1, 5, 4'h9, 4'hA, 0, 1},
            '{1'b0, 4'h6, 1'b1, 1'b0, 0, 4'h0, 4'h0, 0, 0},
            '{1'b1, 4'h6, 1'b1, 1'b0, 0, 4'h0, 4'h0, 0, 0},
            '{1'b1, 4'h7, 1'b1, 1'b1, 0, 4'h7, 4'hF, 1, 1},
            '{1'b1, 4'h7, 1'b1, 1'b0, 0, 4'h0, 4'h0, 0, 0}
        };

        // Directed table: snapshot, changes, back-pressure, disable and re-enable.
        do_reset();
        foreach (vec[i]) begin
            en0 = vec[i].en; sig0 = vec[i].sig; rdy0 = vec[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), valid0, vec[i].ev);
            chk($sformatf("vec%0d_ts", i), ts0, vec[i].ets);
            chk($sformatf("vec%0d_val", i), val0, vec[i].eval);
            chk($sformatf("vec%0d_mask", i), mask0, vec[i].emask);
            chk($sformatf("vec%0d_kind", i), kind0, vec[i].ekind);
            chk($sformatf("vec%0d_level", i), lvl0, vec[i].elvl);
        end

        // Overflow: ten changes with the reader stalled, then an in-order drain.
        do_reset();
        en0 = 1; sig0 = 4'h0; rdy0 = 0;
        tick(); tick();
        for (int i = 1; i <= 10; i++) begin
            sig0 = 4'(i);
            tick();
        end
        chk("ovf_level", lvl0, 8);
        chk("ovf_flag", ovf0, 1);
        chk("ovf_drop_cnt", drop0, 3);
        chk("ovf_head_kind", kind0, 1);
        rdy0 = 1;
        for (int i = 0; i < 8; i++) tick();
        chk("ovf_drained", lvl0, 0);
        chk("ovf_sticky", ovf0, 1);

        // Full FIFO with a pop and a push in the same cycle loses nothing.
        do_reset();
        en0 = 1; sig0 = 4'h0; rdy0 = 0;
        tick(); tick();
        for (int i = 1; i <= 7; i++) begin
            sig0 = 4'(i);
            tick();
        end
        chk("full_level", lvl0, 8);
        rdy0 = 1; sig0 = 4'hF;
        tick();
        chk("full_pp_level", lvl0, 8);
        chk("full_pp_overflow", ovf0, 0);
        chk("full_pp_drop", drop0, 0);
        for (int i = 0; i < 8; i++) tick();

        // Reset while records are queued, then a fresh snapshot.
        do_reset();
        en0 = 1; sig0 = 4'h0; rdy0 = 0;
        tick(); tick();
        for (int i = 1; i <= 4; i++) begin
            sig0 = 4'(i);
            tick();
        end
        chk("mid_level", lvl0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid0, 0);
        chk("mid_rst_level", lvl0, 0);
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sig0 = 4'h9; rdy0 = 1;
        tick(); tick();
        chk("post_rst_valid", valid0, 1);
        chk("post_rst_kind", kind0, 1);
        chk("post_rst_ts", ts0, 0);
        chk("post_rst_val", val0, 4'h9);

        // Timestamp wrap on the narrow instance, quiet and with a coincident change.
        do_reset();
        en0 = 0; en1 = 1; sig1 = 4'h5; rdy1 = 1;
        for (int k = 0; k <= 36; k++) begin
            if (k == 33) sig1 = 4'h6;
            tick();
            if (k == 16) chk("wrap_quiet_before", valid1, 0);
            if (k == 17) begin
                chk("wrap_valid", valid1, 1);
                chk("wrap_kind", kind1, 2);
                chk("wrap_ts", ts1, 0);
                chk("wrap_mask", mask1, 0);
            end
            if (k == 33) begin
                chk("wrapchg_kind", kind1, 2);
                chk("wrapchg_mask", mask1, 4'h3);
                chk("wrapchg_val", val1, 4'h6);
            end
            if (k == 34) chk("wrapchg_single", valid1, 0);
        end

        // Randomised traffic on both instances against the model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            en0  = ($urandom_range(0, 29) != 0);
            en1  = ($urandom_range(0, 29) != 0);
            rdy0 = ($urandom_range(0, 2) != 0);
            rdy1 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) sig0 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) sig1 = 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signal_change_recorder.md
Name: signal_change_recorder

Overview:
- Capture-side counterpart of the stimulus/dump benches: watches a bundle of DUT signals every clock and records each change as a timestamped record (value, change mask, kind) in an internal FIFO.
- A downstream reader drains records over a valid/ready handshake.
- Provides an on-chip, VCD-like event trace that the vcd_assert flow compares against simulator dumps.

Parameters:
- WIDTH, 4, number of monitored signals
- TS_W, 16, timestamp width in clk cycles; wraps modulo 2^TS_W
- DEPTH, 8, record FIFO depth; power of two, ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  recording enable, level
- sig_in  in  WIDTH  monitored signals, already synchronous to clk
- rec_valid  out  1  record available
- rec_ready  in  1  reader accepts record
- rec_ts  out  TS_W  timestamp of record
- rec_val  out  WIDTH  sig_in value at that timestamp
- rec_mask  out  WIDTH  bits that changed; all ones for SNAPSHOT
- rec_kind  out  2  0 CHANGE, 1 SNAPSHOT, 2 WRAP
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  8  dropped-record count, saturates at 255
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, async), all of the following are 0:
  - outputs: rec_valid, rec_ts, rec_val, rec_mask, rec_kind, overflow, drop_cnt, level
  - internal state: FIFO emptied, ts counter, prev-sample register, FSM=IDLE
- FSM states IDLE, SNAP, RUN:
  - IDLE: ts held at 0; no records. en=1 → SNAP.
  - SNAP (one cycle): push SNAPSHOT record {ts=0, val=sig_in, mask=all ones}; prev←sig_in; ts←1; → RUN (→ IDLE if en=0 that cycle, snapshot still pushed).
  - RUN: each cycle diff = sig_in XOR prev; prev←sig_in; ts←ts+1 (wraps). en=0 → IDLE, ts cleared, no record for that cycle.
- Record generation in RUN, evaluated on ts value of current cycle:
  - diff≠0 and ts≠0: CHANGE {ts, sig_in, diff}.
  - ts==0 (counter just wrapped): WRAP {0, sig_in, diff} pushed even if diff==0. Wrap and change coincide → single WRAP record carrying diff.
  - Otherwise no push. At most one push per cycle.
- Latency: sig_in changes before edge k, sampled in cycle k → record written at edge k+1; with empty FIFO rec_valid=1 after edge k+1 (1-cycle latency). Record ts = counter value during cycle k.
- FIFO: first-word-fall-through, registered outputs. Handshake:
  - Pop on rec_valid&rec_ready.
  - rec_* fields stable while rec_valid=1 and rec_ready=0; rec_valid never drops without a pop.
  - rec_* = 0 when empty.
- Simultaneous push and pop on a full FIFO: pop frees the slot, push accepted, no drop. Push on full without pop: record dropped, overflow←1 (sticky until reset), drop_cnt+1 saturating.
- en deassert: FIFO keeps contents and drains normally; re-enable → fresh SNAP at ts=0.
- Reset mid-operation discards all pending records; rec_valid falls asynchronously.
- level = entries stored; updates at the edge of push/pop.

Decomposition:
- Package scr_pkg: rec_kind encoding constants (KIND_CHANGE, KIND_SNAPSHOT, KIND_WRAP), FSM state enum, packed record typedef {ts, val, mask, kind} parameterized through localparams.
- One natural sub-module: scr_fifo, sync FWFT FIFO, DEPTH×record width, full/empty/level, async active-low reset. Top holds FSM, ts counter, diff logic, overflow/drop counters.

Test Plan (WIDTH=4, TS_W=16, DEPTH=8 unless stated):
- Reset, en=1 at cycle 0 with sig_in=4'b0000, toggle bit0 at cycle 20 and bit1 at cycle 30, rec_ready=1 → records SNAPSHOT{0,0000,1111}, CHANGE{20,0001,0001}, CHANGE{30,0011,0010}, each valid one cycle after sampling.
- sig_in 0000→1010 in one cycle at ts=5 → single CHANGE{5,1010,1010}.
- rec_ready=0, 10 changes on consecutive cycles → level reaches 8, overflow=1, drop_cnt=3 (snapshot plus 7 changes kept). rec_ready=1 then drains 8 records in order with unchanged fields.
- TS_W=4, en held with no changes → WRAP{0,val,0000} every 16 cycles. Change at the wrap cycle → single WRAP with nonzero mask.
- Full FIFO with rec_ready=1 and a change in the same cycle → no drop, overflow stays 0, level stays 8.
- Assert rst_n low mid-burst with 5 queued records → rec_valid=0 and level=0 immediately. After release with en=1 → first record is SNAPSHOT at ts=0.
